tag_array_assoc: RTL and testbench
==================================

# tag_array_assoc

Parametrised set-associative tag array for the memory sub-system cache, generalising the direct-mapped tag memory to N ways. It stores a valid bit, dirty bit and tag per way and line, and performs registered lookups that return hit/way plus a replacement victim. It also runs a self-clearing init sweep after reset. It sits between the cache controller FSM and the data array; the controller issues lookups and tag/state updates.

## Interface
- WAYS, 4, associativity; power of 2, ≥2
- INDEX_LENGTH, from memory_sub_system_param, set index width; NUM_SETS = 2**INDEX_LENGTH
- TAG_LENGTH, from memory_sub_system_param, tag width
- WAY_W, $clog2(WAYS), derived, not overridable

- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high when init sweep done; lookups/updates ignored while low
- lk_valid  in  1  lookup request
- lk_index  in  INDEX_LENGTH  lookup set
- lk_tag  in  TAG_LENGTH  lookup tag
- rsp_valid  out  1  response strobe, one cycle after accepted lookup
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  WAY_W  hit way (lowest matching); 0 on miss
- rsp_dirty  out  1  dirty bit of hit way; 0 on miss
- rsp_victim_way  out  WAY_W  replacement candidate
- rsp_victim_valid  out  1  victim way holds valid line
- rsp_victim_dirty  out  1  victim needs writeback
- rsp_victim_tag  out  TAG_LENGTH  victim's stored tag
- up_valid  in  1  state update request
- up_index  in  INDEX_LENGTH  update set
- up_way  in  WAY_W  update way
- up_tag  in  TAG_LENGTH  tag to write (ignored on invalidate)
- up_dirty  in  1  new dirty bit
- up_inval  in  1  1: clear valid and dirty; 0: write tag, valid=1, dirty=up_dirty

## Operation
- FSM states: INIT, RUN. reset → INIT, sweep counter = 0.
- INIT: each cycle clear valid/dirty for all ways and replacement state of set[counter]; counter++; after set NUM_SETS-1 → RUN. Exactly NUM_SETS cycles. ready=0.
- Reset asserted mid-sweep or in RUN: restart INIT at set 0.
- RUN: ready=1. Lookup reads set, compares lk_tag against all valid ways in parallel.
- Victim: lowest-index invalid way if any; otherwise replacement policy (see Configuration).
- Lookup hit marks hit way most-recently used; miss leaves replacement state unchanged.
- Fill (up_inval=0) marks up_way most-recently used; invalidate leaves replacement state unchanged.
- Same-cycle lookup and update to same set: response reflects pre-update contents (read-before-write); update then applies. If both touch replacement state, update wins.
- Requests during INIT are dropped; rsp_valid stays 0.

## Timing
- Lookup latency 1 cycle: lk_valid at edge N → rsp_* valid after edge N+1 for one cycle. Back-to-back lookups every cycle, no stall.
- Update visible to lookups issued the cycle after up_valid.
- rsp_* fields registered; hold last value when rsp_valid=0.
- Reset values: ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_dirty=0, rsp_victim_way=0, rsp_victim_valid=0, rsp_victim_dirty=0, rsp_victim_tag=0.
- ready rises the cycle after the last sweep write (reset deassert + NUM_SETS cycles).

## Configuration
- TAG_ARRAY_PLRU_EN defined: per-set tree pseudo-LRU (WAYS-1 bits per set); victim follows tree when set is full.
- Undefined: single global WAY_W-bit round-robin pointer, advancing on every fill into a full set; hits do not affect it. No per-set replacement storage.

## Structure
- Add to memory_sub_system_param: WAYS default, tag entry struct (valid, dirty, tag), FSM state enum (INIT, RUN).
- One sub-module: plru_tree (WAYS param; MRU-update and victim-select logic for one set), instantiated only under TAG_ARRAY_PLRU_EN.

## Test plan
(WAYS=4, INDEX_LENGTH=3, TAG_LENGTH=8)
- Reset 1 cycle, release → ready=0 for exactly 8 cycles, then 1; lookup tag 0x00 on every set → rsp_hit=0, rsp_victim_way=0, rsp_victim_valid=0.
- Fill set 5 way 2 tag 0xA3 dirty=1; lookup set 5 tag 0xA3 → next cycle rsp_hit=1, rsp_way=2, rsp_dirty=1; tag 0xA4 → miss, victim_way=0.
- Fill set 1 ways 0..3 tags 0x10..0x13, hit way 0 then 1; lookup miss → PLRU_EN: victim_way=2, victim_tag=0x12; without: victim per round-robin pointer.
- Invalidate set 1 way 3 then lookup 0x13 → miss, victim_way=3, victim_valid=0.
- Same-cycle lookup set 5 tag 0x77 and fill set 5 way 0 tag 0x77 → response miss; lookup next cycle → hit way 0.
- Reset asserted at sweep counter 4 after ~1000 cycles of traffic → sweep restarts, ready after 8 cycles, all prior tags miss.

Source files
------------

// File: rtl/memory_sub_system_param.sv
// Shared parameters and types for the memory sub-system cache: geometry defaults,
// tag entry layout and the tag array controller states.
package memory_sub_system_param;

  localparam int INDEX_LENGTH = 3;
  localparam int TAG_LENGTH   = 8;
  localparam int WAYS_DEFAULT = 4;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_LENGTH-1:0] tag;
  } tag_entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } tag_state_t;

endpackage

// File: rtl/tag_array_assoc_plru.sv
// Tree pseudo-LRU for one set: next state after touching a way, and the way the tree
// points at. Node i has children 2i+1 / 2i+2; a node bit of 1 steers the victim right.
`ifdef TAG_ARRAY_PLRU_EN
module plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  state,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAYS-2:0]  next_state,
  output logic [WAY_W-1:0] victim_way
);

  always_comb begin
    logic [WAY_W-1:0] node;
    logic             b;
    next_state = state;
    node       = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b                = access_way[WAY_W-1-l];
      next_state[node] = ~b;
      node             = WAY_W'(2 * int'(node) + 1 + int'(b));
    end
  end

  always_comb begin
    logic [WAY_W-1:0] node;
    logic             b;
    victim_way = '0;
    node       = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b                       = state[node];
      victim_way[WAY_W-1-l]   = b;
      node                    = WAY_W'(2 * int'(node) + 1 + int'(b));
    end
  end

endmodule
`endif

// File: rtl/tag_array_assoc.sv
// N-way set-associative tag array with registered lookup, victim selection and a post-reset
// clearing sweep. TAG_ARRAY_PLRU_EN selects per-set tree PLRU; otherwise a global round-robin.
module tag_array_assoc #(
  parameter  int WAYS         = memory_sub_system_param::WAYS_DEFAULT,
  parameter  int INDEX_LENGTH = memory_sub_system_param::INDEX_LENGTH,
  parameter  int TAG_LENGTH   = memory_sub_system_param::TAG_LENGTH,
  localparam int WAY_W        = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic                    lk_valid,
  input  logic [INDEX_LENGTH-1:0] lk_index,
  input  logic [TAG_LENGTH-1:0]   lk_tag,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [WAY_W-1:0]        rsp_way,
  output logic                    rsp_dirty,
  output logic [WAY_W-1:0]        rsp_victim_way,
  output logic                    rsp_victim_valid,
  output logic                    rsp_victim_dirty,
  output logic [TAG_LENGTH-1:0]   rsp_victim_tag,
  input  logic                    up_valid,
  input  logic [INDEX_LENGTH-1:0] up_index,
  input  logic [WAY_W-1:0]        up_way,
  input  logic [TAG_LENGTH-1:0]   up_tag,
  input  logic                    up_dirty,
  input  logic                    up_inval
);
  import memory_sub_system_param::*;

  localparam int NUM_SETS = 2 ** INDEX_LENGTH;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_LENGTH-1:0] tag;
  } entry_t;

  tag_state_t              state_q;
  logic [INDEX_LENGTH-1:0] sweep_q;
  entry_t                  mem_q [NUM_SETS][WAYS];

  logic                    lk_hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    free_any;
  logic [WAY_W-1:0]        free_way;
  logic [WAY_W-1:0]        policy_way;
  logic [WAY_W-1:0]        victim_way;
  entry_t                  victim_entry;

  always_comb begin
    lk_hit   = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    // Descending scan so the lowest matching / lowest free way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_q[lk_index][w].valid && mem_q[lk_index][w].tag == lk_tag) begin
        lk_hit  = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!mem_q[lk_index][w].valid) begin
        free_any = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim_way   = free_any ? free_way : policy_way;
  assign victim_entry = mem_q[lk_index][victim_way];

`ifdef TAG_ARRAY_PLRU_EN
  logic [WAYS-2:0]     plru_q      [NUM_SETS];
  logic [WAYS-2:0]     plru_next   [NUM_SETS];
  logic [WAY_W-1:0]    plru_victim [NUM_SETS];
  logic [WAY_W-1:0]    plru_access [NUM_SETS];
  logic [NUM_SETS-1:0] plru_touch;

  // A fill and a hit landing on the same set both want the tree; the fill wins.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      logic fill_s;
      logic hit_s;
      fill_s         = up_valid && !up_inval && (up_index == INDEX_LENGTH'(s));
      hit_s          = lk_valid && lk_hit && (lk_index == INDEX_LENGTH'(s));
      plru_touch[s]  = (state_q == RUN) && (fill_s || hit_s);
      plru_access[s] = fill_s ? up_way : hit_way;
    end
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_plru
    plru_tree #(.WAYS(WAYS)) u_plru (
      .state      (plru_q[s]),
      .access_way (plru_access[s]),
      .next_state (plru_next[s]),
      .victim_way (plru_victim[s])
    );
  end

  assign policy_way = plru_victim[lk_index];
`else
  logic [WAY_W-1:0] rr_q;
  logic             up_set_full;

  always_comb begin
    up_set_full = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      up_set_full = up_set_full & mem_q[up_index][w].valid;
    end
  end

  assign policy_way = rr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= INIT;
      sweep_q          <= '0;
      ready            <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_way          <= '0;
      rsp_dirty        <= 1'b0;
      rsp_victim_way   <= '0;
      rsp_victim_valid <= 1'b0;
      rsp_victim_dirty <= 1'b0;
      rsp_victim_tag   <= '0;
`ifndef TAG_ARRAY_PLRU_EN
      rr_q             <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        INIT: begin
          for (int w = 0; w < WAYS; w++) begin
            mem_q[sweep_q][w].valid <= 1'b0;
            mem_q[sweep_q][w].dirty <= 1'b0;
          end
`ifdef TAG_ARRAY_PLRU_EN
          plru_q[sweep_q] <= '0;
`endif
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == INDEX_LENGTH'(NUM_SETS - 1)) begin
            state_q <= RUN;
            ready   <= 1'b1;
          end
        end
        RUN: begin
          if (lk_valid) begin
            rsp_valid        <= 1'b1;
            rsp_hit          <= lk_hit;
            rsp_way          <= hit_way;
            rsp_dirty        <= lk_hit & mem_q[lk_index][hit_way].dirty;
            rsp_victim_way   <= victim_way;
            rsp_victim_valid <= victim_entry.valid;
            rsp_victim_dirty <= victim_entry.valid & victim_entry.dirty;
            rsp_victim_tag   <= victim_entry.tag;
          end
          if (up_valid) begin
            if (up_inval) begin
              mem_q[up_index][up_way].valid <= 1'b0;
              mem_q[up_index][up_way].dirty <= 1'b0;
            end else begin
              mem_q[up_index][up_way].valid <= 1'b1;
              mem_q[up_index][up_way].dirty <= up_dirty;
              mem_q[up_index][up_way].tag   <= up_tag;
`ifndef TAG_ARRAY_PLRU_EN
              if (up_set_full) rr_q <= rr_q + 1'b1;
`endif
            end
          end
`ifdef TAG_ARRAY_PLRU_EN
          for (int s = 0; s < NUM_SETS; s++) begin
            if (plru_touch[s]) plru_q[s] <= plru_next[s];
          end
`endif
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_array_assoc.sv
// Directed bench for tag_array_assoc (WAYS=4, INDEX_LENGTH=3, TAG_LENGTH=8); expectations
// follow TAG_ARRAY_PLRU_EN when defined, round-robin otherwise.
module tb_tag_array_assoc;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic       lk_valid;
  logic [2:0] lk_index;
  logic [7:0] lk_tag;
  logic       rsp_valid;
  logic       rsp_hit;
  logic [1:0] rsp_way;
  logic       rsp_dirty;
  logic [1:0] rsp_victim_way;
  logic       rsp_victim_valid;
  logic       rsp_victim_dirty;
  logic [7:0] rsp_victim_tag;
  logic       up_valid;
  logic [2:0] up_index;
  logic [1:0] up_way;
  logic [7:0] up_tag;
  logic       up_dirty;
  logic       up_inval;

  int checks = 0;
  int fails  = 0;

  tag_array_assoc #(.WAYS(4), .INDEX_LENGTH(3), .TAG_LENGTH(8)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
    .rsp_victim_way(rsp_victim_way), .rsp_victim_valid(rsp_victim_valid),
    .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag),
    .up_valid(up_valid), .up_index(up_index), .up_way(up_way), .up_tag(up_tag),
    .up_dirty(up_dirty), .up_inval(up_inval)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic lookup(input logic [2:0] idx, input logic [7:0] tag);
    lk_valid = 1'b1; lk_index = idx; lk_tag = tag;
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [2:0] idx, input logic [1:0] way, input logic [7:0] tag,
                        input logic dirty, input logic inval);
    up_valid = 1'b1; up_index = idx; up_way = way; up_tag = tag;
    up_dirty = dirty; up_inval = inval;
    tick();
    up_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    logic seen_rsp;
    n = 0;
    seen_rsp = 1'b0;
    lk_valid = 1'b1; lk_index = 3'd0; lk_tag = 8'h00;
    while (!ready && n < 40) begin
      tick();
      n++;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    lk_valid = 1'b0;
    check({name, "_ready_cycles"}, n, exp_cycles);
    check({name, "_no_rsp_in_init"}, seen_rsp, 1'b0);
  endtask

  initial begin
    reset = 1'b1; lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
    up_valid = 1'b0; up_index = '0; up_way = '0; up_tag = '0; up_dirty = 1'b0; up_inval = 1'b0;
    tick();
    tick();
    check("reset_ready", ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_fields", {rsp_hit, rsp_way, rsp_dirty, rsp_victim_way,
                               rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag}, '0);
    reset = 1'b0;
    wait_ready("init", 8);

    // Empty array: every set misses with victim way 0, not valid.
    for (int s = 0; s < 8; s++) begin
      lookup(3'(s), 8'h00);
      check($sformatf("empty_set%0d", s),
            {rsp_valid, rsp_hit, rsp_victim_way, rsp_victim_valid}, {1'b1, 1'b0, 2'd0, 1'b0});
    end

    update(3'd5, 2'd2, 8'hA3, 1'b1, 1'b0);
    // Back-to-back lookups: hit then miss on consecutive cycles.
    lk_valid = 1'b1; lk_index = 3'd5; lk_tag = 8'hA3;
    tick();
    lk_tag = 8'hA4;
    check("s5_hit_valid", rsp_valid, 1'b1);
    check("s5_hit", {rsp_hit, rsp_way, rsp_dirty}, {1'b1, 2'd2, 1'b1});
    tick();
    lk_valid = 1'b0;
    check("s5_miss", {rsp_valid, rsp_hit, rsp_way, rsp_dirty}, {1'b1, 1'b0, 2'd0, 1'b0});
    check("s5_miss_victim", {rsp_victim_way, rsp_victim_valid}, {2'd0, 1'b0});
    tick();
    check("hold_valid_low", rsp_valid, 1'b0);
    check("hold_fields", {rsp_hit, rsp_victim_way, rsp_victim_valid}, {1'b0, 2'd0, 1'b0});

    // Fill set 1 completely; way 0 dirty.
    for (int w = 0; w < 4; w++) update(3'd1, 2'(w), 8'h10 + 8'(w), (w == 0), 1'b0);
    lookup(3'd1, 8'h10);
    check("s1_hit_w0", {rsp_hit, rsp_way, rsp_dirty}, {1'b1, 2'd0, 1'b1});
    lookup(3'd1, 8'h11);
    check("s1_hit_w1", {rsp_hit, rsp_way, rsp_dirty}, {1'b1, 2'd1, 1'b0});
    lookup(3'd1, 8'h55);
`ifdef TAG_ARRAY_PLRU_EN
    check("s1_full_victim", {rsp_hit, rsp_victim_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag},
          {1'b0, 2'd2, 1'b1, 1'b0, 8'h12});
    update(3'd1, 2'd2, 8'h20, 1'b0, 1'b0);
    lookup(3'd1, 8'h55);
    check("s1_after_fill_victim", {rsp_victim_way, rsp_victim_tag, rsp_victim_dirty}, {2'd0, 8'h10, 1'b1});
`else
    check("s1_full_victim", {rsp_hit, rsp_victim_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag},
          {1'b0, 2'd0, 1'b1, 1'b1, 8'h10});
    update(3'd1, 2'd0, 8'h20, 1'b0, 1'b0);
    lookup(3'd1, 8'h55);
    check("s1_after_fill_victim", {rsp_victim_way, rsp_victim_tag, rsp_victim_dirty}, {2'd1, 8'h11, 1'b0});
`endif

    update(3'd1, 2'd3, 8'h00, 1'b0, 1'b1);
    lookup(3'd1, 8'h13);
    check("s1_inval", {rsp_hit, rsp_victim_way, rsp_victim_valid, rsp_victim_dirty}, {1'b0, 2'd3, 1'b0, 1'b0});

    // Lookup and fill to the same set in one cycle: response sees old contents.
    lk_valid = 1'b1; lk_index = 3'd5; lk_tag = 8'h77;
    up_valid = 1'b1; up_index = 3'd5; up_way = 2'd0; up_tag = 8'h77; up_dirty = 1'b0; up_inval = 1'b0;
    tick();
    lk_valid = 1'b0; up_valid = 1'b0;
    check("rbw_miss", {rsp_valid, rsp_hit, rsp_victim_way, rsp_victim_valid}, {1'b1, 1'b0, 2'd0, 1'b0});
    lookup(3'd5, 8'h77);
    check("rbw_then_hit", {rsp_hit, rsp_way, rsp_dirty}, {1'b1, 2'd0, 1'b0});

    // Background traffic: fill every way of every set, then random lookups/updates.
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) update(3'(s), 2'(w), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < 960; i++) begin
      lk_valid = 1'($urandom_range(0, 1)); lk_index = 3'($urandom_range(0, 7));
      lk_tag = 8'($urandom_range(0, 255));
      up_valid = 1'($urandom_range(0, 1)); up_index = 3'($urandom_range(0, 7));
      up_way = 2'($urandom_range(0, 3)); up_tag = 8'($urandom_range(0, 255));
      up_dirty = 1'($urandom_range(0, 1)); up_inval = 1'b0;
      tick();
    end
    lk_valid = 1'b0; up_valid = 1'b0;

    // Reset, let the sweep reach set 4, then reset again: sweep must restart from 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_sweep_ready", ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("restart", 8);
    for (int s = 0; s < 8; s++) begin
      lookup(3'(s), 8'h77);
      check($sformatf("post_reset_set%0d", s),
            {rsp_valid, rsp_hit, rsp_victim_way, rsp_victim_valid}, {1'b1, 1'b0, 2'd0, 1'b0});
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
